retire_rrat: RTL and testbench

- Retirement register alias table (RRAT): holds the committed arch→phys mapping for 32 architectural registers.
- On each ROB retire of up to 2 instructions, records the new physical tag for each destination.
- Returns the displaced (old) physical tags and their count to the free list. This is the release end of the tag allocate/release loop.
- Exposes the full committed map so the front-end map table can be restored on branch mispredict.

---
 rtl/panda_pkg.sv | 24 ++
 rtl/rrat_free_pack.sv | 55 +++++
 rtl/retire_rrat.sv | 95 +++++++++
 tb/tb_retire_rrat.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/panda_pkg.sv
// Shared widths, sizes and the retire-slot record for the rename/retire path.
// Combinational helpers only; no state and no handshakes.
package panda_pkg;

    localparam int PHYS_TAG_W = 7;
    localparam int ARCH_W     = 5;
    localparam int NUM_PHYS   = 96;
    localparam int NUM_ARCH   = 32;
    localparam int ZERO_REG   = 31;

    localparam logic [PHYS_TAG_W-1:0] NUM_PHYS_TAG  = PHYS_TAG_W'(NUM_PHYS);
    localparam logic [ARCH_W-1:0]     ZERO_REG_ARCH = ARCH_W'(ZERO_REG);

    typedef struct packed {
        logic                  wr;
        logic [ARCH_W-1:0]     ar;
        logic [PHYS_TAG_W-1:0] pr;
    } retire_slot_t;

    function automatic logic tag_ok(input logic [PHYS_TAG_W-1:0] pr);
        return pr < NUM_PHYS_TAG;
    endfunction

endpackage

// File: rtl/rrat_free_pack.sv
// Selects displaced tags for up to two retiring slots and packs them for the free list.
// Purely combinational, zero latency; no backpressure (free list always accepts).
module rrat_free_pack
    import panda_pkg::*;
(
    input  logic [1:0]                     retire_num,
    input  retire_slot_t                   slot0,
    input  retire_slot_t                   slot1,
    input  logic [NUM_ARCH*PHYS_TAG_W-1:0] map_flat,
    output logic                           eff0,
    output logic                           eff1,
    output logic [1:0]                     free_num,
    output logic [PHYS_TAG_W-1:0]          free_pr0,
    output logic [PHYS_TAG_W-1:0]          free_pr1
);

    logic                  num_ge1;
    logic                  num_ge2;
    logic [PHYS_TAG_W-1:0] old0;
    logic [PHYS_TAG_W-1:0] old1;

    // A retire count of 3 is illegal and behaves as 2.
    assign num_ge1 = retire_num != 2'd0;
    assign num_ge2 = retire_num[1];

    assign eff0 = num_ge1 && slot0.wr && (slot0.ar != ZERO_REG_ARCH);
    assign eff1 = num_ge2 && slot1.wr && (slot1.ar != ZERO_REG_ARCH);

    always_comb begin
        old0 = map_flat[int'(slot0.ar)*PHYS_TAG_W +: PHYS_TAG_W];
        // Same-cycle WAW: slot 1 displaces the tag slot 0 just installed.
        if (eff0 && (slot1.ar == slot0.ar))
            old1 = slot0.pr;
        else
            old1 = map_flat[int'(slot1.ar)*PHYS_TAG_W +: PHYS_TAG_W];
    end

    always_comb begin
        free_num = 2'd0;
        free_pr0 = '0;
        free_pr1 = '0;
        if (eff0 && eff1) begin
            free_num = 2'd2;
            free_pr0 = old0;
            free_pr1 = old1;
        end else if (eff0) begin
            free_num = 2'd1;
            free_pr0 = old0;
        end else if (eff1) begin
            free_num = 2'd1;
            free_pr0 = old1;
        end
    end

endmodule

// File: rtl/retire_rrat.sv
// Committed arch->phys map; releases displaced tags. Frees are zero-latency, or one cycle with RRAT_FREE_REG_EN.
// Map visible the cycle after the retire edge; no backpressure, retire is always accepted.
module retire_rrat
    import panda_pkg::*;
(
    input  logic                           clock,
    input  logic                           reset,
    input  logic [1:0]                     rob_retire_num,
    input  logic                           rob_retire_wr0,
    input  logic                           rob_retire_wr1,
    input  logic [ARCH_W-1:0]              rob_retire_ar0,
    input  logic [ARCH_W-1:0]              rob_retire_ar1,
    input  logic [PHYS_TAG_W-1:0]          rob_retire_pr0,
    input  logic [PHYS_TAG_W-1:0]          rob_retire_pr1,
    output logic [1:0]                     fl_free_num,
    output logic [PHYS_TAG_W-1:0]          fl_free_pr0,
    output logic [PHYS_TAG_W-1:0]          fl_free_pr1,
    output logic [NUM_ARCH*PHYS_TAG_W-1:0] rrat_map_out,
    output logic                           rrat_err
);

    logic [PHYS_TAG_W-1:0] map_q [NUM_ARCH];
    retire_slot_t          slot0;
    retire_slot_t          slot1;
    logic                  eff0;
    logic                  eff1;
    logic [1:0]            free_num;
    logic [PHYS_TAG_W-1:0] free_pr0;
    logic [PHYS_TAG_W-1:0] free_pr1;
    logic                  bad_input;

    assign slot0 = '{wr: rob_retire_wr0, ar: rob_retire_ar0, pr: rob_retire_pr0};
    assign slot1 = '{wr: rob_retire_wr1, ar: rob_retire_ar1, pr: rob_retire_pr1};

    always_comb begin
        rrat_map_out = '0;
        for (int i = 0; i < NUM_ARCH; i++)
            rrat_map_out[i*PHYS_TAG_W +: PHYS_TAG_W] = map_q[i];
    end

    rrat_free_pack u_free_pack (
        .retire_num (rob_retire_num),
        .slot0      (slot0),
        .slot1      (slot1),
        .map_flat   (rrat_map_out),
        .eff0       (eff0),
        .eff1       (eff1),
        .free_num   (free_num),
        .free_pr0   (free_pr0),
        .free_pr1   (free_pr1)
    );

    assign bad_input = (rob_retire_num == 2'd3)
                     || (eff0 && !tag_ok(rob_retire_pr0))
                     || (eff1 && !tag_ok(rob_retire_pr1));

    // Slot 1 is written after slot 0 so it wins on a shared arch register.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ARCH; i++)
                map_q[i] <= PHYS_TAG_W'(i);
        end else begin
            if (eff0 && tag_ok(rob_retire_pr0))
                map_q[rob_retire_ar0] <= rob_retire_pr0;
            if (eff1 && tag_ok(rob_retire_pr1))
                map_q[rob_retire_ar1] <= rob_retire_pr1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            rrat_err <= 1'b0;
        else if (bad_input)
            rrat_err <= 1'b1;
    end

`ifdef RRAT_FREE_REG_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            fl_free_num <= 2'd0;
            fl_free_pr0 <= '0;
            fl_free_pr1 <= '0;
        end else begin
            fl_free_num <= free_num;
            fl_free_pr0 <= free_pr0;
            fl_free_pr1 <= free_pr1;
        end
    end
`else
    assign fl_free_num = free_num;
    assign fl_free_pr0 = free_pr0;
    assign fl_free_pr1 = free_pr1;
`endif

endmodule

// File: tb/tb_retire_rrat.sv
// Directed table-driven bench for retire_rrat, covering both free-output timings.
module tb_retire_rrat;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   rob_retire_num;
    logic         rob_retire_wr0, rob_retire_wr1;
    logic [4:0]   rob_retire_ar0, rob_retire_ar1;
    logic [6:0]   rob_retire_pr0, rob_retire_pr1;
    logic [1:0]   fl_free_num;
    logic [6:0]   fl_free_pr0, fl_free_pr1;
    logic [223:0] rrat_map_out;
    logic         rrat_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    retire_rrat dut (
        .clock          (clock),
        .reset          (reset),
        .rob_retire_num (rob_retire_num),
        .rob_retire_wr0 (rob_retire_wr0),
        .rob_retire_wr1 (rob_retire_wr1),
        .rob_retire_ar0 (rob_retire_ar0),
        .rob_retire_ar1 (rob_retire_ar1),
        .rob_retire_pr0 (rob_retire_pr0),
        .rob_retire_pr1 (rob_retire_pr1),
        .fl_free_num    (fl_free_num),
        .fl_free_pr0    (fl_free_pr0),
        .fl_free_pr1    (fl_free_pr1),
        .rrat_map_out   (rrat_map_out),
        .rrat_err       (rrat_err)
    );

    typedef struct {
        int num, wr0, ar0, pr0, wr1, ar1, pr1;
        int e_num, e_p0, e_p1;
        int chk_ar, e_map, e_err;
    } vec_t;

    vec_t vecs[12];
    int   prev_num, prev_p0, prev_p1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int map_at(input int i);
        return int'(rrat_map_out[i*7 +: 7]);
    endfunction

    function automatic vec_t mk(input int num, input int wr0, input int ar0, input int pr0,
                                input int wr1, input int ar1, input int pr1,
                                input int e_num, input int e_p0, input int e_p1,
                                input int chk_ar, input int e_map, input int e_err);
        vec_t v;
        v.num = num; v.wr0 = wr0; v.ar0 = ar0; v.pr0 = pr0;
        v.wr1 = wr1; v.ar1 = ar1; v.pr1 = pr1;
        v.e_num = e_num; v.e_p0 = e_p0; v.e_p1 = e_p1;
        v.chk_ar = chk_ar; v.e_map = e_map; v.e_err = e_err;
        return v;
    endfunction

    task automatic drive(input int num, input int wr0, input int ar0, input int pr0,
                         input int wr1, input int ar1, input int pr1);
        rob_retire_num = 2'(num);
        rob_retire_wr0 = 1'(wr0); rob_retire_ar0 = 5'(ar0); rob_retire_pr0 = 7'(pr0);
        rob_retire_wr1 = 1'(wr1); rob_retire_ar1 = 5'(ar1); rob_retire_pr1 = 7'(pr1);
    endtask

    task automatic check_identity(input string tag);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s_map%0d", tag, i), map_at(i), i);
    endtask

    initial begin
        // num, wr0,ar0,pr0, wr1,ar1,pr1, exp frees (num,p0,p1), map probe ar/value, err
        vecs[0]  = mk(2, 1,  3, 40, 1,  7, 41, 2,  3,  7,  3, 40, 0);
        vecs[1]  = mk(0, 1,  7, 70, 1,  8, 71, 0,  0,  0,  7, 41, 0);
        vecs[2]  = mk(2, 1,  5, 50, 1,  5, 51, 2,  5, 50,  5, 51, 0);
        vecs[3]  = mk(2, 0,  4, 10, 1,  9, 60, 1,  9,  0,  9, 60, 0);
        vecs[4]  = mk(2, 0,  4, 11, 1, 31, 61, 0,  0,  0, 31, 31, 0);
        vecs[5]  = mk(1, 1,  3, 42, 1,  3, 43, 1, 40,  0,  3, 42, 0);
        vecs[6]  = mk(2, 1, 31, 12, 1,  3, 44, 1, 42,  0,  3, 44, 0);
        vecs[7]  = mk(2, 1,  5, 52, 1,  5, 53, 2, 51, 52,  5, 53, 0);
        vecs[8]  = mk(1, 1,  2,100, 0,  0,  0, 1,  2,  0,  2,  2, 1);
        vecs[9]  = mk(3, 1, 10, 62, 1, 11, 63, 2, 10, 11, 11, 63, 1);
        vecs[10] = mk(0, 0,  0,  0, 0,  0,  0, 0,  0,  0, 10, 62, 1);
        vecs[11] = mk(0, 0,  0,  0, 0,  0,  0, 0,  0,  0,  8,  8, 1);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #2;
        check_identity("reset");
        chk("reset_free_num", int'(fl_free_num), 0);
        chk("reset_free_pr0", int'(fl_free_pr0), 0);
        chk("reset_free_pr1", int'(fl_free_pr1), 0);
        chk("reset_err", int'(rrat_err), 0);

        prev_num = 0; prev_p0 = 0; prev_p1 = 0;
        for (int v = 0; v < 12; v++) begin
            @(negedge clock);
            drive(vecs[v].num, vecs[v].wr0, vecs[v].ar0, vecs[v].pr0,
                  vecs[v].wr1, vecs[v].ar1, vecs[v].pr1);
            #2;
`ifdef RRAT_FREE_REG_EN
            chk($sformatf("v%0d_pre_num", v), int'(fl_free_num), prev_num);
            chk($sformatf("v%0d_pre_pr0", v), int'(fl_free_pr0), prev_p0);
            chk($sformatf("v%0d_pre_pr1", v), int'(fl_free_pr1), prev_p1);
`else
            chk($sformatf("v%0d_num", v), int'(fl_free_num), vecs[v].e_num);
            chk($sformatf("v%0d_pr0", v), int'(fl_free_pr0), vecs[v].e_p0);
            chk($sformatf("v%0d_pr1", v), int'(fl_free_pr1), vecs[v].e_p1);
`endif
            @(posedge clock);
            #1;
`ifdef RRAT_FREE_REG_EN
            chk($sformatf("v%0d_reg_num", v), int'(fl_free_num), vecs[v].e_num);
            chk($sformatf("v%0d_reg_pr0", v), int'(fl_free_pr0), vecs[v].e_p0);
            chk($sformatf("v%0d_reg_pr1", v), int'(fl_free_pr1), vecs[v].e_p1);
`endif
            chk($sformatf("v%0d_map%0d", v, vecs[v].chk_ar), map_at(vecs[v].chk_ar), vecs[v].e_map);
            chk($sformatf("v%0d_err", v), int'(rrat_err), vecs[v].e_err);
            prev_num = vecs[v].e_num; prev_p0 = vecs[v].e_p0; prev_p1 = vecs[v].e_p1;
        end

        // Reset asserted while a two-wide retire is on the inputs: reset wins.
        @(negedge clock);
        drive(2, 1, 3, 45, 1, 7, 46);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_identity("rst_mid");
        chk("rst_mid_err", int'(rrat_err), 0);
`ifdef RRAT_FREE_REG_EN
        chk("rst_mid_free_num", int'(fl_free_num), 0);
        chk("rst_mid_free_pr0", int'(fl_free_pr0), 0);
`endif
        @(negedge clock);
        reset = 1'b0;
        drive(0, 1, 3, 45, 1, 7, 46);
        #2;
        chk("idle_free_num", int'(fl_free_num), 0);
        chk("idle_free_pr0", int'(fl_free_pr0), 0);
        chk("idle_free_pr1", int'(fl_free_pr1), 0);
        @(posedge clock);
        #1;
        check_identity("idle");
        chk("idle_err", int'(rrat_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
